// File: rtl/counter_cmd_seq_pkg.sv
// ============================================================================
// counter_cmd_seq_pkg : shared op encodings, state type and default widths
// Rev 1.0
// ============================================================================
`default_nettype none

package counter_cmd_seq_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_N_W   = 8;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_UP    = 2'b10;
    localparam logic [1:0] OP_DOWN  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_LD   = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/counter_cmd_seq.sv
// ============================================================================
// counter_cmd_seq : turns CLEAR/LOAD/UP-N/DOWN-N commands into counter control
// Rev 1.0
// ============================================================================
`default_nettype none

module counter_cmd_seq
    import counter_cmd_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_W   = DEF_N_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             cmd_done,
    output logic             cnt_clr,
    output logic             cnt_ld,
    output logic             cnt_mode,
    output logic [WIDTH-1:0] cnt_d_in,
    output logic [WIDTH-1:0] exp_count
);

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] shadow_q,    shadow_d;
    logic [WIDTH-1:0] data_q,      data_d;
    logic [N_W-1:0]   remaining_q, remaining_d;
    logic             dir_q,       dir_d;

    logic             cmd_ready_q, cmd_ready_d;
    logic             cmd_done_q,  cmd_done_d;
    logic             cnt_clr_q,   cnt_clr_d;
    logic             cnt_ld_q,    cnt_ld_d;
    logic             cnt_mode_q,  cnt_mode_d;
    logic [WIDTH-1:0] cnt_d_in_q,  cnt_d_in_d;

    logic [N_W-1:0]   w_step;
    assign w_step = cmd_data[N_W-1:0];

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        data_d      = data_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    case (cmd_op)
                        OP_CLEAR: state_d = ST_CLR;
                        OP_LOAD: begin
                            state_d = ST_LD;
                            data_d  = cmd_data;
                        end
                        default: begin
                            if (w_step == '0) begin
                                // Zero-length step: reload the shadow as a one-cycle no-op
                                state_d = ST_LD;
                                data_d  = shadow_q;
                            end else begin
                                state_d     = ST_RUN;
                                remaining_d = w_step;
                                dir_d       = ~cmd_op[0];
                            end
                        end
                    endcase
                end
            end
            ST_CLR: begin
                shadow_d = '0;
                state_d  = ST_IDLE;
            end
            ST_LD: begin
                shadow_d = data_q;
                state_d  = ST_IDLE;
            end
            ST_RUN: begin
                shadow_d    = dir_q ? shadow_q + WIDTH'(1) : shadow_q - WIDTH'(1);
                remaining_d = remaining_q - N_W'(1);
                if (remaining_q <= N_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // present during the cycle the counter samples them.
    always_comb begin
        cmd_ready_d = 1'b0;
        cmd_done_d  = 1'b0;
        cnt_clr_d   = 1'b0;
        cnt_ld_d    = 1'b0;
        cnt_mode_d  = 1'b0;
        cnt_d_in_d  = '0;

        case (state_d)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                cnt_ld_d    = 1'b1;
                cnt_d_in_d  = shadow_d;
            end
            ST_CLR: begin
                cnt_clr_d  = 1'b1;
                cmd_done_d = 1'b1;
            end
            ST_LD: begin
                cnt_ld_d   = 1'b1;
                cnt_d_in_d = data_d;
                cmd_done_d = 1'b1;
            end
            ST_RUN: begin
                cnt_mode_d = dir_d;
                cnt_d_in_d = shadow_d;
                cmd_done_d = (remaining_d == N_W'(1));
            end
            default: begin
                cmd_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            data_q      <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            cmd_done_q  <= 1'b0;
            cnt_clr_q   <= 1'b1;
            cnt_ld_q    <= 1'b0;
            cnt_mode_q  <= 1'b0;
            cnt_d_in_q  <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            data_q      <= data_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            cmd_ready_q <= cmd_ready_d;
            cmd_done_q  <= cmd_done_d;
            cnt_clr_q   <= cnt_clr_d;
            cnt_ld_q    <= cnt_ld_d;
            cnt_mode_q  <= cnt_mode_d;
            cnt_d_in_q  <= cnt_d_in_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign cmd_done  = cmd_done_q;
    assign cnt_clr   = cnt_clr_q;
    assign cnt_ld    = cnt_ld_q;
    assign cnt_mode  = cnt_mode_q;
    assign cnt_d_in  = cnt_d_in_q;
    assign exp_count = shadow_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_cmd_seq.sv
// ============================================================================
// tb_counter_cmd_seq : directed bench for counter_cmd_seq with a counter model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_counter_cmd_seq;

    localparam logic [1:0] T_CLEAR = 2'b00;
    localparam logic [1:0] T_LOAD  = 2'b01;
    localparam logic [1:0] T_UP    = 2'b10;
    localparam logic [1:0] T_DOWN  = 2'b11;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_done;
    logic       cnt_clr;
    logic       cnt_ld;
    logic       cnt_mode;
    logic [7:0] cnt_d_in;
    logic [7:0] exp_count;

    int passed = 0;
    int total  = 0;

    counter_cmd_seq #(.WIDTH(8), .N_W(8)) dut (
        .clk       (clk),
        .clr       (clr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_done  (cmd_done),
        .cnt_clr   (cnt_clr),
        .cnt_ld    (cnt_ld),
        .cnt_mode  (cnt_mode),
        .cnt_d_in  (cnt_d_in),
        .exp_count (exp_count)
    );

    always #5 clk = ~clk;

    // Downstream 8-bit counter driven by the sequencer outputs
    logic [7:0] model_cnt;
    always @(posedge clk or posedge clr) begin
        if (clr)          model_cnt <= 8'h00;
        else if (cnt_clr) model_cnt <= 8'h00;
        else if (cnt_ld)  model_cnt <= cnt_d_in;
        else if (cnt_mode) model_cnt <= model_cnt + 8'h01;
        else              model_cnt <= model_cnt - 8'h01;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for a single accepting edge, then scrambles the bus
    task automatic send(input logic [1:0] op, input logic [7:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        cmd_data  = 8'hA5;
    endtask

    task automatic test_reset();
        tick();
        total++; if (cnt_clr !== 1'b1) $display("FAIL rst_cnt_clr got %0b want 1", cnt_clr); else passed++;
        total++; if (cmd_ready !== 1'b0) $display("FAIL rst_ready got %0b want 0", cmd_ready); else passed++;
        total++; if (cnt_ld !== 1'b0) $display("FAIL rst_ld got %0b want 0", cnt_ld); else passed++;
        total++; if (cmd_done !== 1'b0) $display("FAIL rst_done got %0b want 0", cmd_done); else passed++;
        repeat (2) tick();
        @(negedge clk);
        clr = 1'b0;
        repeat (5) tick();
        total++; if (cnt_clr !== 1'b0) $display("FAIL idle_cnt_clr got %0b want 0", cnt_clr); else passed++;
        total++; if (cnt_ld !== 1'b1) $display("FAIL idle_ld got %0b want 1", cnt_ld); else passed++;
        total++; if (cnt_d_in !== 8'h00) $display("FAIL idle_d_in got %h want 00", cnt_d_in); else passed++;
        total++; if (exp_count !== 8'h00) $display("FAIL idle_exp got %h want 00", exp_count); else passed++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL idle_ready got %0b want 1", cmd_ready); else passed++;
    endtask

    task automatic test_load_up();
        send(T_LOAD, 8'h09);
        total++; if (cnt_ld !== 1'b1) $display("FAIL ld_cnt_ld got %0b want 1", cnt_ld); else passed++;
        total++; if (cnt_d_in !== 8'h09) $display("FAIL ld_d_in got %h want 09", cnt_d_in); else passed++;
        total++; if (cmd_done !== 1'b1) $display("FAIL ld_done got %0b want 1", cmd_done); else passed++;
        total++; if (cmd_ready !== 1'b0) $display("FAIL ld_ready got %0b want 0", cmd_ready); else passed++;
        tick();
        total++; if (exp_count !== 8'h09) $display("FAIL ld_exp got %h want 09", exp_count); else passed++;
        total++; if (cmd_done !== 1'b0) $display("FAIL ld_done_clear got %0b want 0", cmd_done); else passed++;
        send(T_UP, 8'd3);
        total++; if (cnt_mode !== 1'b1) $display("FAIL up_mode got %0b want 1", cnt_mode); else passed++;
        total++; if (cnt_ld !== 1'b0) $display("FAIL up_ld got %0b want 0", cnt_ld); else passed++;
        total++; if (cmd_done !== 1'b0) $display("FAIL up_done0 got %0b want 0", cmd_done); else passed++;
        tick();
        total++; if (exp_count !== 8'h0A) $display("FAIL up_exp1 got %h want 0a", exp_count); else passed++;
        total++; if (cmd_done !== 1'b0) $display("FAIL up_done1 got %0b want 0", cmd_done); else passed++;
        tick();
        total++; if (exp_count !== 8'h0B) $display("FAIL up_exp2 got %h want 0b", exp_count); else passed++;
        total++; if (cmd_done !== 1'b1) $display("FAIL up_done2 got %0b want 1", cmd_done); else passed++;
        tick();
        total++; if (exp_count !== 8'h0C) $display("FAIL up_exp3 got %h want 0c", exp_count); else passed++;
        total++; if (cmd_done !== 1'b0) $display("FAIL up_done3 got %0b want 0", cmd_done); else passed++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL up_ready got %0b want 1", cmd_ready); else passed++;
        total++; if (model_cnt !== 8'h0C) $display("FAIL up_model got %h want 0c", model_cnt); else passed++;
    endtask

    task automatic test_down_wrap();
        send(T_LOAD, 8'h01);
        tick();
        send(T_DOWN, 8'd3);
        total++; if (cnt_mode !== 1'b0) $display("FAIL dn_mode got %0b want 0", cnt_mode); else passed++;
        total++; if (cnt_ld !== 1'b0) $display("FAIL dn_ld got %0b want 0", cnt_ld); else passed++;
        tick();
        total++; if (exp_count !== 8'h00) $display("FAIL dn_exp1 got %h want 00", exp_count); else passed++;
        tick();
        total++; if (exp_count !== 8'hFF) $display("FAIL dn_exp2 got %h want ff", exp_count); else passed++;
        total++; if (cmd_done !== 1'b1) $display("FAIL dn_done got %0b want 1", cmd_done); else passed++;
        tick();
        total++; if (exp_count !== 8'hFE) $display("FAIL dn_exp3 got %h want fe", exp_count); else passed++;
        tick();
        total++; if (exp_count !== 8'hFE) $display("FAIL dn_frozen got %h want fe", exp_count); else passed++;
        total++; if (cnt_ld !== 1'b1) $display("FAIL dn_hold_ld got %0b want 1", cnt_ld); else passed++;
        total++; if (cnt_d_in !== 8'hFE) $display("FAIL dn_hold_d got %h want fe", cnt_d_in); else passed++;
        total++; if (model_cnt !== 8'hFE) $display("FAIL dn_model got %h want fe", model_cnt); else passed++;
        send(T_LOAD, 8'hFF);
        tick();
        send(T_UP, 8'd1);
        total++; if (cmd_done !== 1'b1) $display("FAIL wrap_done got %0b want 1", cmd_done); else passed++;
        tick();
        total++; if (exp_count !== 8'h00) $display("FAIL wrap_exp got %h want 00", exp_count); else passed++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL wrap_ready got %0b want 1", cmd_ready); else passed++;
    endtask

    task automatic test_zero_step_clear();
        send(T_LOAD, 8'h22);
        tick();
        send(T_UP, 8'd0);
        total++; if (cnt_ld !== 1'b1) $display("FAIL z_ld got %0b want 1", cnt_ld); else passed++;
        total++; if (cnt_d_in !== 8'h22) $display("FAIL z_d_in got %h want 22", cnt_d_in); else passed++;
        total++; if (cmd_done !== 1'b1) $display("FAIL z_done got %0b want 1", cmd_done); else passed++;
        tick();
        total++; if (exp_count !== 8'h22) $display("FAIL z_exp got %h want 22", exp_count); else passed++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL z_ready got %0b want 1", cmd_ready); else passed++;
        send(T_CLEAR, 8'h77);
        total++; if (cnt_clr !== 1'b1) $display("FAIL clr_cnt_clr got %0b want 1", cnt_clr); else passed++;
        total++; if (cnt_ld !== 1'b0) $display("FAIL clr_ld got %0b want 0", cnt_ld); else passed++;
        total++; if (cmd_done !== 1'b1) $display("FAIL clr_done got %0b want 1", cmd_done); else passed++;
        tick();
        total++; if (exp_count !== 8'h00) $display("FAIL clr_exp got %h want 00", exp_count); else passed++;
        total++; if (cnt_clr !== 1'b0) $display("FAIL clr_release got %0b want 0", cnt_clr); else passed++;
        total++; if (model_cnt !== 8'h00) $display("FAIL clr_model got %h want 00", model_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        send(T_LOAD, 8'h30);
        tick();
        cmd_valid = 1'b1;
        cmd_op    = T_UP;
        cmd_data  = 8'd4;
        tick();
        cmd_op   = T_LOAD;
        cmd_data = 8'h55;
        for (int i = 1; i <= 3; i++) begin
            tick();
            want = 8'h30 + 8'(i);
            total++; if (exp_count !== want) $display("FAIL b2b_exp%0d got %h want %h", i, exp_count, want); else passed++;
            total++; if (cmd_done !== (i == 3)) $display("FAIL b2b_done%0d got %0b want %0b", i, cmd_done, (i == 3)); else passed++;
        end
        tick();
        total++; if (exp_count !== 8'h34) $display("FAIL b2b_end got %h want 34", exp_count); else passed++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready got %0b want 1", cmd_ready); else passed++;
        tick();
        cmd_valid = 1'b0;
        total++; if (cnt_d_in !== 8'h55) $display("FAIL b2b_second got %h want 55", cnt_d_in); else passed++;
        total++; if (cmd_done !== 1'b1) $display("FAIL b2b_second_done got %0b want 1", cmd_done); else passed++;
        tick();
        total++; if (exp_count !== 8'h55) $display("FAIL b2b_final got %h want 55", exp_count); else passed++;
        total++; if (model_cnt !== 8'h55) $display("FAIL b2b_model got %h want 55", model_cnt); else passed++;
    endtask

    task automatic test_reset_mid_run();
        send(T_LOAD, 8'h40);
        tick();
        send(T_UP, 8'd5);
        tick();
        tick();
        total++; if (exp_count !== 8'h42) $display("FAIL mr_pre got %h want 42", exp_count); else passed++;
        #2;
        clr = 1'b1;
        #1;
        total++; if (cnt_clr !== 1'b1) $display("FAIL mr_cnt_clr got %0b want 1", cnt_clr); else passed++;
        total++; if (exp_count !== 8'h00) $display("FAIL mr_exp got %h want 00", exp_count); else passed++;
        total++; if (cmd_done !== 1'b0) $display("FAIL mr_done got %0b want 0", cmd_done); else passed++;
        total++; if (cmd_ready !== 1'b0) $display("FAIL mr_ready got %0b want 0", cmd_ready); else passed++;
        tick();
        @(negedge clk);
        clr = 1'b0;
        tick();
        tick();
        total++; if (cmd_ready !== 1'b1) $display("FAIL mr_post_ready got %0b want 1", cmd_ready); else passed++;
        total++; if (cnt_ld !== 1'b1) $display("FAIL mr_post_ld got %0b want 1", cnt_ld); else passed++;
        total++; if (exp_count !== 8'h00) $display("FAIL mr_post_exp got %h want 00", exp_count); else passed++;
        total++; if (cmd_done !== 1'b0) $display("FAIL mr_post_done got %0b want 0", cmd_done); else passed++;
        total++; if (model_cnt !== 8'h00) $display("FAIL mr_model got %h want 00", model_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_load_up();
        test_down_wrap();
        test_zero_step_clear();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
